// File: rtl/vector_pkg.sv
// Shared message layout for the vector front-end: {meth, v} padded to the transport width.
package vector_pkg;

  localparam int VEC_MEETH_W = 32;
  localparam int VEC_V_W     = 32;
  localparam int VEC_XPORT_W = 704;
  localparam int VEC_PAD_W   = VEC_XPORT_W - VEC_MEETH_W - VEC_V_W;

  typedef struct packed {
    logic [VEC_PAD_W-1:0]   pad;
    logic [VEC_MEETH_W-1:0] meth;
    logic [VEC_V_W-1:0]     v;
  } vec_msg_t;

  function automatic logic [VEC_XPORT_W-1:0] pack_msg(input logic [VEC_MEETH_W-1:0] meth,
                                                      input logic [VEC_V_W-1:0] v);
    vec_msg_t m;
    m.pad  = '0;
    m.meth = meth;
    m.v    = v;
    return m;
  endfunction

  function automatic vec_msg_t unpack_msg(input logic [VEC_XPORT_W-1:0] raw);
    return vec_msg_t'(raw);
  endfunction

endpackage

// File: rtl/vector_fifo.sv
// Circular-buffer FIFO between the vector say method and respond_rule; head visible the cycle after enqueue.
// Define VECTOR_FIFO_PIPELINE_EN to let a same-cycle dequeue make room for an enqueue when full.
module vector_fifo
  import vector_pkg::*;
#(
  parameter int WIDTH = VEC_XPORT_W,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_enq__ENA,
  input  logic [WIDTH-1:0] in_enq_v,
  output logic             in_enq__RDY,
  input  logic             out_deq__ENA,
  output logic             out_deq__RDY,
  output logic [WIDTH-1:0] out_first,
  output logic             out_first__RDY,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             empty;
  logic             full;
  logic             enq;
  logic             deq;

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

`ifdef VECTOR_FIFO_PIPELINE_EN
  // Full is fine if the head leaves this cycle; the write lands in the slot being vacated.
  assign in_enq__RDY = !full | out_deq__ENA;
`else
  assign in_enq__RDY = !full;
`endif
  assign out_deq__RDY   = !empty;
  assign out_first__RDY = !empty;

  assign enq = in_enq__ENA & in_enq__RDY;
  assign deq = out_deq__ENA & out_deq__RDY;

  assign out_first = mem[rd_ptr];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + AW'(1);
      if (deq) rd_ptr <= rd_ptr + AW'(1);
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset so it can map onto an SRAM.
  always_ff @(posedge CLK) begin
    if (enq) mem[wr_ptr] <= in_enq_v;
  end

endmodule
